// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Turns an instruction descriptor into an RV32I word and
//               tags it with its instruction-memory byte address. It is a
//               single pipeline stage with a valid/ready handshake on both
//               sides. Illegal descriptors are consumed, flagged and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_aluop,
  input  logic [2:0]        in_f3,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  // Descriptor kinds
  localparam logic [2:0] c_k_r      = 3'd0;
  localparam logic [2:0] c_k_opimm  = 3'd1;
  localparam logic [2:0] c_k_load   = 3'd2;
  localparam logic [2:0] c_k_store  = 3'd3;
  localparam logic [2:0] c_k_branch = 3'd4;
  localparam logic [2:0] c_k_jal    = 3'd5;
  localparam logic [2:0] c_k_jalr   = 3'd6;

  // Opcodes
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  localparam logic [ADDR_W-1:0] c_step   = ADDR_W'(4);
  localparam logic [7:0]        c_cnt_max = 8'hFF;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic        w_accept;
  logic        w_illegal;
  logic        w_shift;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic [2:0]  w_alu_f3;
  logic [6:0]  w_alu_f7;
  logic [31:0] w_instr;

  assign in_ready  = !restart && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

  // A signed immediate fits in N bits when all bits from N-1 upward agree
  assign w_fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);
  assign w_shift  = (in_aluop == 4'd5) || (in_aluop == 4'd6) || (in_aluop == 4'd7);

  // ALU operation to funct3/funct7, shared by R and OP-IMM forms
  always_comb begin
    w_alu_f3 = 3'b000;
    case (in_aluop)
      4'd0, 4'd1: w_alu_f3 = 3'b000;
      4'd2:       w_alu_f3 = 3'b111;
      4'd3:       w_alu_f3 = 3'b110;
      4'd4:       w_alu_f3 = 3'b100;
      4'd5:       w_alu_f3 = 3'b001;
      4'd6, 4'd7: w_alu_f3 = 3'b101;
      4'd8:       w_alu_f3 = 3'b010;
      4'd9:       w_alu_f3 = 3'b011;
      default:    w_alu_f3 = 3'b000;
    endcase
    w_alu_f7 = ((in_aluop == 4'd1) || (in_aluop == 4'd7)) ? 7'b0100000 : 7'b0000000;
  end

  // Legality of the descriptor currently presented
  always_comb begin
    w_illegal = 1'b0;
    case (in_kind)
      c_k_r:      w_illegal = (in_aluop > 4'd9);
      c_k_opimm:  w_illegal = (in_aluop > 4'd9) || (in_aluop == 4'd1) ||
                              (!w_shift && !w_fits12);
      c_k_load:   w_illegal = (in_f3 == 3'b011) || (in_f3 == 3'b110) ||
                              (in_f3 == 3'b111) || !w_fits12;
      c_k_store:  w_illegal = (in_f3 > 3'b010) || !w_fits12;
      c_k_branch: w_illegal = (in_f3 == 3'b010) || (in_f3 == 3'b011) ||
                              in_imm[0] || !w_fits13;
      c_k_jal:    w_illegal = in_imm[0] || !w_fits21;
      c_k_jalr:   w_illegal = !w_fits12;
      default:    w_illegal = 1'b1;
    endcase
  end

  // Instruction word assembly for each format
  always_comb begin
    w_instr = 32'h0000_0000;
    case (in_kind)
      c_k_r:      w_instr = {w_alu_f7, in_rs2, in_rs1, w_alu_f3, in_rd, c_op_r};
      c_k_opimm:  w_instr = w_shift
                          ? {w_alu_f7, in_imm[4:0], in_rs1, w_alu_f3, in_rd, c_op_opimm}
                          : {in_imm[11:0], in_rs1, w_alu_f3, in_rd, c_op_opimm};
      c_k_load:   w_instr = {in_imm[11:0], in_rs1, in_f3, in_rd, c_op_load};
      c_k_store:  w_instr = {in_imm[11:5], in_rs2, in_rs1, in_f3, in_imm[4:0], c_op_store};
      c_k_branch: w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_f3,
                             in_imm[4:1], in_imm[11], c_op_branch};
      c_k_jal:    w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, c_op_jal};
      c_k_jalr:   w_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, c_op_jalr};
      default:    w_instr = 32'h0000_0000;
    endcase
  end

  // Output stage, address counter and error pulse; restart overrides all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_addr  <= '0;
      r_cnt   <= BASE_ADDR;
      r_err   <= 1'b0;
    end else if (restart) begin
      r_valid <= 1'b0;
      r_cnt   <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept && !w_illegal) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
        r_addr  <= r_cnt;
        r_cnt   <= r_cnt + c_step;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Saturating count of dropped descriptors; restart leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_illegal && (r_err_cnt != c_cnt_max)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed vector table plus hand-written handshake, restart,
//               saturation and asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_aluop;
  logic [2:0]  in_f3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  aluop;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_aluop(in_aluop), .in_f3(in_f3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] kind, input logic [3:0] aluop,
                              input logic [2:0] f3, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic legal,
                              input logic [31:0] exp);
    vec_t v;
    v.kind = kind; v.aluop = aluop; v.f3 = f3; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.imm = imm; v.legal = legal; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_kind  = v.kind;  in_aluop = v.aluop; in_f3 = v.f3;
    in_rd    = v.rd;    in_rs1   = v.rs1;   in_rs2 = v.rs2;
    in_imm   = v.imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_kind  = 3'd0; in_aluop = 4'd0; in_f3 = 3'd0;
    in_rd    = 5'd0; in_rs1   = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    int          exp_errs;
    vec_t        va, vb, vill;

    // kind aluop f3 rd rs1 rs2 imm legal expected
    vecs[0]  = mk(3'd0, 4'd0, 3'd0, 5'd3,  5'd1,  5'd2,  32'd0,          1'b1, 32'h002081B3);
    vecs[1]  = mk(3'd0, 4'd1, 3'd0, 5'd5,  5'd6,  5'd7,  32'd0,          1'b1, 32'h407302B3);
    vecs[2]  = mk(3'd1, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF,   1'b1, 32'hFFF00093);
    vecs[3]  = mk(3'd1, 4'd7, 3'd0, 5'd2,  5'd2,  5'd0,  32'd3,          1'b1, 32'h40315113);
    vecs[4]  = mk(3'd3, 4'd0, 3'd2, 5'd0,  5'd1,  5'd2,  32'd8,          1'b1, 32'h0020A423);
    vecs[5]  = mk(3'd5, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'd8,          1'b1, 32'h008000EF);
    vecs[6]  = mk(3'd2, 4'd0, 3'd2, 5'd5,  5'd2,  5'd0,  32'd4,          1'b1, 32'h00412283);
    vecs[7]  = mk(3'd4, 4'd0, 3'd0, 5'd0,  5'd1,  5'd2,  32'd8,          1'b1, 32'h00208463);
    vecs[8]  = mk(3'd4, 4'd0, 3'd1, 5'd0,  5'd3,  5'd0,  32'hFFFFFFFC,   1'b1, 32'hFE019EE3);
    vecs[9]  = mk(3'd6, 4'd0, 3'd5, 5'd0,  5'd1,  5'd0,  32'd0,          1'b1, 32'h00008067);
    vecs[10] = mk(3'd0, 4'd9, 3'd0, 5'd10, 5'd11, 5'd12, 32'd0,          1'b1, 32'h00C5B533);
    vecs[11] = mk(3'd1, 4'd5, 3'd0, 5'd1,  5'd1,  5'd0,  32'd31,         1'b1, 32'h01F09093);
    vecs[12] = mk(3'd1, 4'd4, 3'd0, 5'd4,  5'd5,  5'd0,  32'd2047,       1'b1, 32'h7FF2C213);
    vecs[13] = mk(3'd1, 4'd6, 3'd0, 5'd1,  5'd1,  5'd0,  32'hFFFFFFE5,   1'b1, 32'h0050D093);
    vecs[14] = mk(3'd5, 4'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFF00000,   1'b1, 32'h8000006F);
    vecs[15] = mk(3'd4, 4'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFFF000,   1'b1, 32'h80000063);
    vecs[16] = mk(3'd1, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'd2048,       1'b0, 32'd0);
    vecs[17] = mk(3'd3, 4'd0, 3'd2, 5'd0,  5'd1,  5'd2,  32'hFFFFF7FF,   1'b0, 32'd0);
    vecs[18] = mk(3'd5, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'h00100000,   1'b0, 32'd0);
    vecs[19] = mk(3'd4, 4'd0, 3'd0, 5'd0,  5'd1,  5'd2,  32'd4096,       1'b0, 32'd0);
    vecs[20] = mk(3'd2, 4'd0, 3'd3, 5'd1,  5'd1,  5'd0,  32'd0,          1'b0, 32'd0);
    vecs[21] = mk(3'd3, 4'd0, 3'd3, 5'd0,  5'd1,  5'd2,  32'd0,          1'b0, 32'd0);
    vecs[22] = mk(3'd0, 4'd10,3'd0, 5'd1,  5'd1,  5'd1,  32'd0,          1'b0, 32'd0);
    vecs[23] = mk(3'd4, 4'd0, 3'd2, 5'd0,  5'd1,  5'd2,  32'd8,          1'b0, 32'd0);
    vecs[24] = mk(3'd5, 4'd0, 3'd0, 5'd1,  5'd0,  5'd0,  32'd7,          1'b0, 32'd0);
    vecs[25] = mk(3'd0, 4'd0, 3'd0, 5'd1,  5'd1,  5'd1,  32'd0,          1'b1, 32'h001080B3);

    // Reset state
    rst_n = 1'b0; restart = 1'b0; out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset out_addr",  out_addr,  32'd0);
    chk("reset err",       32'(err),  32'd0);
    chk("reset err_cnt",   32'(err_cnt), 32'd0);
    chk("reset in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal prelude: three dropped descriptors, nothing emitted
    exp_errs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      case (i)
        0:       drive(mk(3'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0));
        1:       drive(mk(3'd1, 4'd1, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 32'd0));
        default: drive(mk(3'd7, 4'd0, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, 32'd0));
      endcase
      tick();
      exp_errs++;
      chk("prelude err", 32'(err), 32'd1);
      chk("prelude out_valid", 32'(out_valid), 32'd0);
    end
    chk("prelude err_cnt", 32'(err_cnt), 32'd3);

    // Vector table, back-to-back, consumer always ready
    exp_addr = 32'd0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      tick();
      if (vecs[i].legal) begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].exp);
        chk($sformatf("v%0d out_addr", i),  out_addr,  exp_addr);
        chk($sformatf("v%0d err", i), 32'(err), 32'd0);
        exp_addr = exp_addr + 32'd4;
      end else begin
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d err", i), 32'(err), 32'd1);
        exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
      end
      chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(exp_errs));
    end
    @(negedge clk);
    idle();
    tick();
    chk("drain out_valid", 32'(out_valid), 32'd0);
    chk("drain err", 32'(err), 32'd0);

    // Restart to rewind the counter
    @(negedge clk);
    restart = 1'b1;
    tick();
    chk("restart1 out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    restart = 1'b0;

    // Backpressure: two descriptors offered while the consumer stalls
    va = vecs[0];
    vb = vecs[1];
    @(negedge clk);
    out_ready = 1'b0;
    drive(va);
    tick();
    chk("bp A valid", 32'(out_valid), 32'd1);
    chk("bp A instr", out_instr, va.exp);
    chk("bp A addr",  out_addr,  32'd0);
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    drive(vb);
    tick();
    chk("bp A held instr", out_instr, va.exp);
    chk("bp A held addr",  out_addr,  32'd0);
    chk("bp in_ready still low", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready released", 32'(in_ready), 32'd1);
    tick();
    chk("bp B valid", 32'(out_valid), 32'd1);
    chk("bp B instr", out_instr, vb.exp);
    chk("bp B addr",  out_addr,  32'd4);
    @(negedge clk);
    drive(vecs[2]);
    tick();
    chk("bp C addr", out_addr, 32'd8);
    @(negedge clk);
    drive(vecs[3]);
    tick();
    chk("pre-restart addr", out_addr, 32'h0C);

    // Restart with a pending word and counter at 0x10
    @(negedge clk);
    out_ready = 1'b0;
    restart   = 1'b1;
    drive(vecs[4]);
    #1;
    chk("restart in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("restart2 out_valid", 32'(out_valid), 32'd0);
    chk("restart2 err_cnt", 32'(err_cnt), 32'(exp_errs));
    @(negedge clk);
    restart   = 1'b0;
    out_ready = 1'b1;
    drive(vecs[5]);
    tick();
    chk("post-restart instr", out_instr, vecs[5].exp);
    chk("post-restart addr",  out_addr,  32'd0);

    // Saturation of the illegal counter
    vill = mk(3'd7, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      drive(vill);
    end
    tick();
    chk("sat err_cnt", 32'(err_cnt), 32'd255);
    chk("sat err", 32'(err), 32'd1);
    @(negedge clk);
    idle();
    tick();
    chk("sat err_cnt hold", 32'(err_cnt), 32'd255);
    chk("sat err clear", 32'(err), 32'd0);

    // Asynchronous reset while a word is stalled at the output
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[7]);
    tick();
    chk("mid valid before reset", 32'(out_valid), 32'd1);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_instr", out_instr, 32'd0);
    chk("async out_addr",  out_addr,  32'd0);
    chk("async err_cnt",   32'(err_cnt), 32'd0);
    chk("async err",       32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(vecs[10]);
    tick();
    chk("after reset addr", out_addr, 32'd0);
    chk("after reset instr", out_instr, vecs[10].exp);
    @(negedge clk);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
